// File: rtl/calpoc_pkg.sv
// CalPOC shared types: FSM state encoding, ALU operator codes and default sizing.
// Debounce sizing is only consumed when CALPOC_DEBOUNCE_EN is defined.
package calpoc_pkg;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    EXEC    = 2'd2,
    SHOW    = 2'd3
  } state_t;

  localparam logic OP_OR  = 1'b0;
  localparam logic OP_XOR = 1'b1;

  localparam int CALPOC_WIDTH           = 3;
  localparam int CALPOC_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/calpoc_btn_cond.sv
// Button conditioner: 2-flop sync, optional debounce (CALPOC_DEBOUNCE_EN), rising-edge press pulse.
// Press appears 2 clocks after input rise (3 to take effect), plus DEBOUNCE_CYCLES when debounced.
module calpoc_btn_cond
`ifdef CALPOC_DEBOUNCE_EN
  #(parameter int DEBOUNCE_CYCLES = calpoc_pkg::CALPOC_DEBOUNCE_CYCLES)
`endif
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic w_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

`ifdef CALPOC_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_filt;

  // Filtered level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else if (r_sync2 == r_filt) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      r_cnt  <= '0;
      r_filt <= r_sync2;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_level = r_filt;
`else
  assign w_level = r_sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= 1'b0;
    else        r_prev <= w_level;
  end

  assign o_press = w_level & ~r_prev;

endmodule

// File: rtl/calpoc_ctrl.sv
// CalPOC sequencing controller: bit-serial operand entry, one-cycle ALU execute, result capture.
// Equals edge to disp_valid is 4 clocks (plus DEBOUNCE_CYCLES with CALPOC_DEBOUNCE_EN).
module calpoc_ctrl
  import calpoc_pkg::*;
#(
  parameter int WIDTH           = CALPOC_WIDTH,
  parameter int DEBOUNCE_CYCLES = CALPOC_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_one,
  input  logic             btn_zero,
  input  logic             btn_or,
  input  logic             btn_xor,
  input  logic             btn_equals,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] led_a,
  output logic [WIDTH-1:0] led_b,
  output logic [WIDTH-1:0] disp_value,
  output logic             disp_valid,
  output logic [1:0]       state
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [5:0] w_raw;
  logic [5:0] w_press;

  assign w_raw = {btn_clear, btn_equals, btn_xor, btn_or, btn_zero, btn_one};

  for (genvar g = 0; g < 6; g++) begin : g_btn
`ifdef CALPOC_DEBOUNCE_EN
    calpoc_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond (
`else
    calpoc_btn_cond u_cond (
`endif
      .clk    (clk),
      .rst_n  (rst_n),
      .i_btn  (w_raw[g]),
      .o_press(w_press[g])
    );
  end

  logic w_dig_vld, w_dig_bit, w_op_vld, w_op_val, w_eq, w_clr;

  // Conflicting digit or operator pairs cancel each other.
  assign w_dig_vld = w_press[0] ^ w_press[1];
  assign w_dig_bit = w_press[0];
  assign w_op_vld  = w_press[2] ^ w_press[3];
  assign w_op_val  = w_press[3];
  assign w_eq      = w_press[4];
  assign w_clr     = w_press[5];

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_disp, w_a_nxt, w_b_nxt, w_disp_nxt;
  logic [CW-1:0]    r_cnt_a, r_cnt_b, w_cnt_a_nxt, w_cnt_b_nxt;
  logic             r_op, r_dvld, w_op_nxt, w_dvld_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ENTER_A;
      r_a     <= '0;
      r_b     <= '0;
      r_disp  <= '0;
      r_cnt_a <= '0;
      r_cnt_b <= '0;
      r_op    <= OP_OR;
      r_dvld  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_disp  <= w_disp_nxt;
      r_cnt_a <= w_cnt_a_nxt;
      r_cnt_b <= w_cnt_b_nxt;
      r_op    <= w_op_nxt;
      r_dvld  <= w_dvld_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_disp_nxt  = r_disp;
    w_cnt_a_nxt = r_cnt_a;
    w_cnt_b_nxt = r_cnt_b;
    w_op_nxt    = r_op;
    w_dvld_nxt  = r_dvld;
    if (w_clr) begin
      w_state_nxt = ENTER_A;
      w_a_nxt     = '0;
      w_b_nxt     = '0;
      w_disp_nxt  = '0;
      w_cnt_a_nxt = '0;
      w_cnt_b_nxt = '0;
      w_op_nxt    = OP_OR;
      w_dvld_nxt  = 1'b0;
    end else begin
      case (r_state)
        ENTER_A: begin
          if (w_eq) begin
            w_state_nxt = ENTER_A;
          end else if (w_op_vld) begin
            w_op_nxt    = w_op_val;
            w_state_nxt = ENTER_B;
          end else if (w_dig_vld && r_cnt_a != CW'(WIDTH)) begin
            w_a_nxt     = {r_a[WIDTH-2:0], w_dig_bit};
            w_cnt_a_nxt = r_cnt_a + 1'b1;
          end
        end
        ENTER_B: begin
          if (w_eq) begin
            w_state_nxt = EXEC;
          end else if (w_op_vld) begin
            w_op_nxt = w_op_val;
          end else if (w_dig_vld && r_cnt_b != CW'(WIDTH)) begin
            w_b_nxt     = {r_b[WIDTH-2:0], w_dig_bit};
            w_cnt_b_nxt = r_cnt_b + 1'b1;
          end
        end
        EXEC: begin
          w_disp_nxt  = alu_result;
          w_dvld_nxt  = 1'b1;
          w_state_nxt = SHOW;
        end
        SHOW: begin
          // An operator chains on the shown result; a digit starts a fresh calculation.
          if (w_eq) begin
            w_state_nxt = SHOW;
          end else if (w_op_vld) begin
            w_a_nxt     = r_disp;
            w_cnt_a_nxt = CW'(WIDTH);
            w_b_nxt     = '0;
            w_cnt_b_nxt = '0;
            w_op_nxt    = w_op_val;
            w_dvld_nxt  = 1'b0;
            w_state_nxt = ENTER_B;
          end else if (w_dig_vld) begin
            w_a_nxt     = WIDTH'(w_dig_bit);
            w_cnt_a_nxt = CW'(1);
            w_b_nxt     = '0;
            w_cnt_b_nxt = '0;
            w_dvld_nxt  = 1'b0;
            w_state_nxt = ENTER_A;
          end
        end
        default: w_state_nxt = ENTER_A;
      endcase
    end
  end

  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_op     = r_op;
  assign led_a      = r_a;
  assign led_b      = r_b;
  assign disp_value = r_disp;
  assign disp_valid = r_dvld;
  assign state      = r_state;

endmodule

// File: tb/tb_calpoc_ctrl.sv
// Directed bench for calpoc_ctrl with a behavioural OR/XOR ALU on the result input.
module tb_calpoc_ctrl;

  localparam int W = 3;
`ifdef CALPOC_DEBOUNCE_EN
  localparam int LAT = 3 + 16;
`else
  localparam int LAT = 3;
`endif
  localparam int B_ONE = 0, B_ZERO = 1, B_OR = 2, B_XOR = 3, B_EQ = 4, B_CLR = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [5:0]   btn = '0;
  logic [W-1:0] alu_a, alu_b, alu_result, led_a, led_b, disp_value;
  logic         alu_op, disp_valid;
  logic [1:0]   state;

  int errors = 0;
  int checks = 0;
  int exec_cnt = 0;
  int e0;

  always #5 clk = ~clk;

  assign alu_result = alu_op ? (alu_a ^ alu_b) : (alu_a | alu_b);

  always @(posedge clk) if (state == 2'd2) exec_cnt++;

  calpoc_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_one(btn[B_ONE]), .btn_zero(btn[B_ZERO]), .btn_or(btn[B_OR]),
    .btn_xor(btn[B_XOR]), .btn_equals(btn[B_EQ]), .btn_clear(btn[B_CLR]),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .led_a(led_a), .led_b(led_b), .disp_value(disp_value),
    .disp_valid(disp_valid), .state(state)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int idx);
    btn[idx] = 1'b1;
    tick(LAT);
    btn[idx] = 1'b0;
    tick(LAT);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick(2);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (led_a !== 3'b000) begin errors++; $display("FAIL reset_led_a got=%b exp=000", led_a); end
    checks++; if (led_b !== 3'b000) begin errors++; $display("FAIL reset_led_b got=%b exp=000", led_b); end
    checks++; if (alu_op !== 1'b0) begin errors++; $display("FAIL reset_alu_op got=%b exp=0", alu_op); end
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL reset_disp_valid got=%b exp=0", disp_valid); end
    checks++; if (disp_value !== 3'b000) begin errors++; $display("FAIL reset_disp_value got=%b exp=000", disp_value); end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_xor_calc;
    press(B_ONE); press(B_ZERO); press(B_ONE);
    checks++; if (led_a !== 3'b101) begin errors++; $display("FAIL xor_led_a got=%b exp=101", led_a); end
    press(B_XOR);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL xor_state_b got=%0d exp=1", state); end
    checks++; if (alu_op !== 1'b1) begin errors++; $display("FAIL xor_alu_op got=%b exp=1", alu_op); end
    press(B_ZERO); press(B_ONE); press(B_ONE);
    checks++; if (led_b !== 3'b011) begin errors++; $display("FAIL xor_led_b got=%b exp=011", led_b); end
    e0 = exec_cnt;
    btn[B_EQ] = 1'b1;
    tick(LAT);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL xor_exec_state got=%0d exp=2", state); end
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL xor_exec_valid got=%b exp=0", disp_valid); end
    checks++; if (alu_a !== 3'b101 || alu_b !== 3'b011) begin errors++; $display("FAIL xor_alu_operands got=%b,%b exp=101,011", alu_a, alu_b); end
    tick(1);
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL xor_show_state got=%0d exp=3", state); end
    checks++; if (disp_valid !== 1'b1) begin errors++; $display("FAIL xor_disp_valid got=%b exp=1", disp_valid); end
    checks++; if (disp_value !== 3'b110) begin errors++; $display("FAIL xor_disp_value got=%b exp=110", disp_value); end
    checks++; if (exec_cnt - e0 !== 1) begin errors++; $display("FAIL xor_exec_cycles got=%0d exp=1", exec_cnt - e0); end
    btn[B_EQ] = 1'b0;
    tick(LAT);
  endtask

  task automatic test_chain;
    press(B_CLR);
    checks++; if (state !== 2'd0 || led_a !== 3'b000) begin errors++; $display("FAIL chain_clear got=%0d,%b exp=0,000", state, led_a); end
    press(B_ONE); press(B_ZERO); press(B_ZERO);
    press(B_OR);
    press(B_ZERO); press(B_ZERO); press(B_ONE);
    press(B_EQ);
    checks++; if (disp_value !== 3'b101 || disp_valid !== 1'b1) begin errors++; $display("FAIL chain_first got=%b,%b exp=101,1", disp_value, disp_valid); end
    press(B_OR);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL chain_state got=%0d exp=1", state); end
    checks++; if (led_a !== 3'b101 || led_b !== 3'b000) begin errors++; $display("FAIL chain_operands got=%b,%b exp=101,000", led_a, led_b); end
    checks++; if (disp_valid !== 1'b0 || alu_op !== 1'b0) begin errors++; $display("FAIL chain_valid_op got=%b,%b exp=0,0", disp_valid, alu_op); end
    press(B_ZERO); press(B_ONE); press(B_ZERO);
    press(B_EQ);
    checks++; if (led_a !== 3'b101) begin errors++; $display("FAIL chain_led_a got=%b exp=101", led_a); end
    checks++; if (disp_value !== 3'b111 || disp_valid !== 1'b1) begin errors++; $display("FAIL chain_second got=%b,%b exp=111,1", disp_value, disp_valid); end
  endtask

  task automatic test_saturate_conflict;
    press(B_CLR);
    press(B_ONE); press(B_ONE); press(B_ONE); press(B_ZERO);
    checks++; if (led_a !== 3'b111) begin errors++; $display("FAIL sat_led_a got=%b exp=111", led_a); end
    press(B_OR);
    btn[B_ONE] = 1'b1; btn[B_ZERO] = 1'b1;
    tick(LAT);
    btn[B_ONE] = 1'b0; btn[B_ZERO] = 1'b0;
    tick(LAT);
    checks++; if (led_b !== 3'b000) begin errors++; $display("FAIL conflict_digit got=%b exp=000", led_b); end
    btn[B_OR] = 1'b1; btn[B_XOR] = 1'b1;
    tick(LAT);
    btn[B_OR] = 1'b0; btn[B_XOR] = 1'b0;
    tick(LAT);
    checks++; if (alu_op !== 1'b0) begin errors++; $display("FAIL conflict_op got=%b exp=0", alu_op); end
    press(B_ONE);
    checks++; if (led_b !== 3'b001) begin errors++; $display("FAIL sat_led_b got=%b exp=001", led_b); end
  endtask

  task automatic test_clear;
    press(B_CLR);
    press(B_ONE); press(B_ONE); press(B_ZERO);
    press(B_XOR);
    press(B_ZERO); press(B_ONE);
    checks++; if (led_a !== 3'b110 || led_b !== 3'b001) begin errors++; $display("FAIL clr_setup got=%b,%b exp=110,001", led_a, led_b); end
    press(B_CLR);
    checks++; if (led_a !== 3'b000 || led_b !== 3'b000) begin errors++; $display("FAIL clr_operands got=%b,%b exp=000,000", led_a, led_b); end
    checks++; if (state !== 2'd0 || disp_valid !== 1'b0 || alu_op !== 1'b0) begin errors++; $display("FAIL clr_state got=%0d,%b,%b exp=0,0,0", state, disp_valid, alu_op); end
    press(B_ONE); press(B_OR); press(B_ONE);
    e0 = exec_cnt;
    btn[B_CLR] = 1'b1; btn[B_EQ] = 1'b1;
    tick(LAT);
    checks++; if (state !== 2'd0 || led_a !== 3'b000) begin errors++; $display("FAIL clr_vs_eq got=%0d,%b exp=0,000", state, led_a); end
    btn[B_CLR] = 1'b0; btn[B_EQ] = 1'b0;
    tick(LAT);
    checks++; if (state !== 2'd0 || exec_cnt - e0 !== 0) begin errors++; $display("FAIL clr_vs_eq_after got=%0d,%0d exp=0,0", state, exec_cnt - e0); end
  endtask

  task automatic test_equals_ignored;
    press(B_EQ);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL eq_in_enter_a got=%0d exp=0", state); end
    press(B_ONE); press(B_OR); press(B_ONE);
    e0 = exec_cnt;
    btn[B_EQ] = 1'b1;
    tick(LAT + 1);
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL eq_hold_show got=%0d exp=3", state); end
    tick(10);
    checks++; if (state !== 2'd3 || disp_valid !== 1'b1) begin errors++; $display("FAIL eq_hold_state got=%0d,%b exp=3,1", state, disp_valid); end
    checks++; if (disp_value !== 3'b001) begin errors++; $display("FAIL eq_hold_value got=%b exp=001", disp_value); end
    checks++; if (exec_cnt - e0 !== 1) begin errors++; $display("FAIL eq_hold_execs got=%0d exp=1", exec_cnt - e0); end
    btn[B_EQ] = 1'b0;
    tick(LAT);
  endtask

  task automatic test_async_reset;
    press(B_CLR);
    press(B_ONE); press(B_ONE); press(B_XOR); press(B_ONE);
    btn[B_EQ] = 1'b1;
    tick(LAT);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL arst_in_exec got=%0d exp=2", state); end
    rst_n = 1'b0;
    #1;
    checks++; if (state !== 2'd0 || alu_op !== 1'b0) begin errors++; $display("FAIL arst_state got=%0d,%b exp=0,0", state, alu_op); end
    checks++; if (led_a !== 3'b000 || led_b !== 3'b000) begin errors++; $display("FAIL arst_operands got=%b,%b exp=000,000", led_a, led_b); end
    checks++; if (disp_valid !== 1'b0 || disp_value !== 3'b000) begin errors++; $display("FAIL arst_disp got=%b,%b exp=0,000", disp_valid, disp_value); end
    btn[B_EQ] = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(LAT + 2);
    checks++; if (state !== 2'd0 || disp_valid !== 1'b0) begin errors++; $display("FAIL arst_after got=%0d,%b exp=0,0", state, disp_valid); end
  endtask

`ifdef CALPOC_DEBOUNCE_EN
  task automatic test_glitch;
    press(B_CLR);
    btn[B_ONE] = 1'b1;
    tick(5);
    btn[B_ONE] = 1'b0;
    tick(40);
    checks++; if (led_a !== 3'b000) begin errors++; $display("FAIL glitch_led_a got=%b exp=000", led_a); end
  endtask
`endif

  initial begin
    test_reset();
    test_xor_calc();
    test_chain();
    test_saturate_conflict();
    test_clear();
    test_equals_ignored();
    test_async_reset();
`ifdef CALPOC_DEBOUNCE_EN
    test_glitch();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/calpoc_ctrl.md
Name: calpoc_ctrl

Overview:
Sequencing controller for the CalPOC two-operand bitwise calculator.
- Conditions the six push-button inputs and builds operands A and B bit-serially.
- Latches the operator, drives the shared ALU for one execute cycle and captures its result for the seven-segment display.
- Sits between the board buttons and the alu/dff/shiftreg datapath; owns all calculator state.

Parameters:
WIDTH, 3, operand/result width in bits (digits per operand)
DEBOUNCE_CYCLES, 16, stable-sample count required per button (used only with CALPOC_DEBOUNCE_EN)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
btn_one  in  1  raw level, digit 1
btn_zero  in  1  raw level, digit 0
btn_or  in  1  raw level, operator OR
btn_xor  in  1  raw level, operator XOR
btn_equals  in  1  raw level, execute
btn_clear  in  1  raw level, clear all
alu_a  out  WIDTH  ALU operand A (= A register)
alu_b  out  WIDTH  ALU operand B (= B register)
alu_op  out  1  0=OR, 1=XOR
alu_result  in  WIDTH  combinational ALU result
led_a  out  WIDTH  operand A display
led_b  out  WIDTH  operand B display
disp_value  out  WIDTH  result for seven-seg
disp_valid  out  1  result shown; seven-seg blanks when 0
state  out  2  FSM state (debug)

Behaviour:
- Reset: all registers 0, state=ENTER_A, alu_op=0, disp_valid=0, digit counters 0. Reset is asynchronous: asserting rst_n low mid-EXEC or mid-entry discards everything immediately.
- Button conditioning (per button):
  - 2-flop synchronizer, then a prev flop.
  - press = sync & ~prev, a one-cycle pulse.
  - Input rising before edge 1 takes effect at edge 3.
  - Holding a button generates one press only.
- Press priority, same cycle: clear > equals > operator > digit.
  - btn_one and btn_zero pressed together: both ignored.
  - btn_or and btn_xor pressed together: both ignored.
- Digit entry: reg <= {reg[WIDTH-2:0], bit}, MSB-first.
  - Counter saturates at WIDTH; further digits are ignored and the register is unchanged.
- States:
  - ENTER_A:
    - digit shifts into A.
    - operator latches alu_op and moves to ENTER_B.
    - equals is ignored.
  - ENTER_B:
    - digit shifts into B.
    - operator overwrites alu_op and stays in ENTER_B.
    - equals moves to EXEC, even with zero B digits (B=0).
  - EXEC: exactly one cycle; alu_a/alu_b/alu_op stable. Next edge: disp_value<=alu_result, disp_valid<=1, state->SHOW. Buttons pressed during EXEC are dropped, except clear.
  - SHOW:
    - digit clears B, disp_valid and counters; A<=bit (count 1); state->ENTER_A.
    - operator sets A<=disp_value (count WIDTH), B<=0, latches alu_op, disp_valid<=0; state->ENTER_B (chaining).
    - equals is ignored.
- Clear, any state: A, B, disp_value, disp_valid, counters and alu_op go to 0; state->ENTER_A next edge.
- Latency: equals input edge to disp_valid=1 is 4 clocks without debounce.
- State encoding: ENTER_A=0, ENTER_B=1, EXEC=2, SHOW=3.

Optional Feature:
CALPOC_DEBOUNCE_EN
- Defined: each button passes through a counter after the synchronizer. The filtered level changes only after the synced input has differed from it for DEBOUNCE_CYCLES consecutive cycles; edge detection runs on the filtered level. Press latency becomes 3+DEBOUNCE_CYCLES clocks.
- Undefined: no counter, DEBOUNCE_CYCLES unused, latency as above.

Decomposition:
- Package calpoc_pkg:
  - state enum (ENTER_A..SHOW) and op constants OP_OR=0, OP_XOR=1.
  - default WIDTH and DEBOUNCE_CYCLES.
- One sub-module, calpoc_btn_cond: synchronizer, optional debounce and edge detector. Instantiated six times; outputs the press pulse.

Test Plan:
- Digits 1,0,1; XOR; 0,1,1; equals -> led_a=101, led_b=011, alu_op=1, EXEC lasts 1 cycle, disp_value=110, disp_valid=1 four clocks after equals.
- Digits 1,0,0; OR; 0,0,1; equals -> disp_value=101. Then OR; 0,1,0; equals -> led_a=101, disp_value=111 (chaining).
- Digits 1,1,1,0 into A -> led_a stays 111. btn_one and btn_zero pressed in the same cycle -> no change.
- Mid-B entry (A=110, B=01): clear -> led_a=0, led_b=0, disp_valid=0, state=ENTER_A. Clear held with equals -> clear wins.
- Equals in ENTER_A, and equals held for 10 cycles in SHOW -> no state change, single execute only.
- rst_n low during EXEC -> all outputs 0 immediately, state=ENTER_A. With CALPOC_DEBOUNCE_EN, a 5-cycle glitch (DEBOUNCE_CYCLES=16) -> no press.
